// File: rtl/pharmacy_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : pharmacy_dispatcher
// Purpose  : Command-side controller for a 10-entry min-heap store.
//            Converts arrival, serve and dump requests into heap command
//            sequences and collects the heap's list stream.
// Ports    : clk, rst_n                     - clock, async active-low reset
//            tick                           - advance time-stamp counter
//            arr_valid/arr_id/arr_ready     - arrival (check-in) handshake
//            srv_req/srv_done/srv_empty/srv_id
//                                           - serve (pop minimum) request/result
//            dump_req/dump_valid/dump_id/dump_done
//                                           - full listing request/stream
//            occupancy                      - entries currently held
//            hm_mode/hm_studentID/hm_checkInTime
//                                           - heap command outputs
//            hm_listOutput/hm_listBusy/hm_ready
//                                           - heap list stream / status inputs
// Revision : 1.0 - initial release
// ============================================================================
module pharmacy_dispatcher #(
  parameter int DEPTH    = 10,
  parameter int TIME_MAX = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       arr_valid,
  input  logic [4:0] arr_id,
  output logic       arr_ready,
  input  logic       srv_req,
  output logic       srv_done,
  output logic       srv_empty,
  output logic [4:0] srv_id,
  input  logic       dump_req,
  output logic       dump_valid,
  output logic [4:0] dump_id,
  output logic       dump_done,
  output logic [3:0] occupancy,
  output logic [1:0] hm_mode,
  output logic [4:0] hm_studentID,
  output logic [7:0] hm_checkInTime,
  input  logic [4:0] hm_listOutput,
  input  logic       hm_listBusy,
  input  logic       hm_ready
);

  localparam logic [3:0] c_depth    = 4'(DEPTH);
  localparam logic [4:0] c_time_max = 5'(TIME_MAX);

  localparam logic [1:0] c_mode_list   = 2'd0;
  localparam logic [1:0] c_mode_nop    = 2'd1;
  localparam logic [1:0] c_mode_insert = 2'd2;
  localparam logic [1:0] c_mode_delete = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEEK = 2'd1,
    DEL  = 2'd2,
    DUMP = 2'd3
  } state_t;

  state_t     r_state;
  logic [4:0] r_time;
  logic [3:0] r_cnt;   // edges spent in DUMP; capture starts on the second
  logic       w_arr_accept;
  logic       w_unused_hm_ready;

  // hm_ready is informational only; the command schedule is fixed.
  assign w_unused_hm_ready = hm_ready;

  assign arr_ready    = rst_n && (r_state == IDLE) && (occupancy < c_depth) && !srv_req;
  assign w_arr_accept = arr_valid && arr_ready;

  // Time stamp saturates rather than wrapping so late arrivals never
  // appear older than early ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_time <= 5'd0;
    end else if (tick && (r_time != c_time_max)) begin
      r_time <= r_time + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= 4'd0;
      occupancy      <= 4'd0;
      hm_mode        <= c_mode_nop;
      hm_studentID   <= 5'd0;
      hm_checkInTime <= 8'd0;
      srv_done       <= 1'b0;
      srv_empty      <= 1'b0;
      srv_id         <= 5'd0;
      dump_valid     <= 1'b0;
      dump_id        <= 5'd0;
      dump_done      <= 1'b0;
    end else begin
      hm_mode    <= c_mode_nop;
      srv_done   <= 1'b0;
      srv_empty  <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (srv_req) begin
            if (occupancy != 4'd0) begin
              hm_mode <= c_mode_list;
              r_state <= PEEK;
            end else begin
              srv_done  <= 1'b1;
              srv_empty <= 1'b1;
            end
          end else if (w_arr_accept) begin
            hm_mode        <= c_mode_insert;
            hm_studentID   <= arr_id;
            hm_checkInTime <= {3'b000, r_time};
            occupancy      <= occupancy + 4'd1;
          end else if (dump_req) begin
            if (occupancy != 4'd0) begin
              hm_mode <= c_mode_list;
              r_cnt   <= 4'd0;
              r_state <= DUMP;
            end else begin
              dump_done <= 1'b1;
            end
          end
        end

        // Heap latches the root on this edge; delete it on the next.
        PEEK: begin
          hm_mode <= c_mode_delete;
          r_state <= DEL;
        end

        DEL: begin
          srv_id   <= hm_listOutput;
          srv_done <= 1'b1;
          if (occupancy != 4'd0) begin
            occupancy <= occupancy - 4'd1;
          end
          r_state <= IDLE;
        end

        // List mode is held for occupancy+1 edges; the first edge only
        // loads the heap's output register, the remaining ones capture.
        DUMP: begin
          if (r_cnt != 4'd0) begin
            dump_valid <= hm_listBusy;
            dump_id    <= hm_listOutput;
          end
          if (r_cnt == occupancy) begin
            dump_done <= 1'b1;
            r_state   <= IDLE;
          end else begin
            hm_mode <= c_mode_list;
          end
          r_cnt <= r_cnt + 4'd1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pharmacy_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pharmacy_dispatcher
// Purpose  : Self-checking bench for pharmacy_dispatcher with a behavioural
//            sorted-array heap model driving the list stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pharmacy_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       arr_valid = 1'b0;
  logic [4:0] arr_id = 5'd0;
  logic       arr_ready;
  logic       srv_req = 1'b0;
  logic       srv_done;
  logic       srv_empty;
  logic [4:0] srv_id;
  logic       dump_req = 1'b0;
  logic       dump_valid;
  logic [4:0] dump_id;
  logic       dump_done;
  logic [3:0] occupancy;
  logic [1:0] hm_mode;
  logic [4:0] hm_studentID;
  logic [7:0] hm_checkInTime;
  logic [4:0] m_out;
  logic       m_busy;
  logic       hm_ready;

  int checks = 0;
  int failures = 0;

  logic [4:0] exp_id_q[$];
  logic [4:0] exp_tm_q[$];
  logic [4:0] exp_srv_q[$];
  logic [4:0] exp_dump_q[$];

  always #5 clk = ~clk;

  pharmacy_dispatcher #(.DEPTH(10), .TIME_MAX(31)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .arr_valid     (arr_valid),
    .arr_id        (arr_id),
    .arr_ready     (arr_ready),
    .srv_req       (srv_req),
    .srv_done      (srv_done),
    .srv_empty     (srv_empty),
    .srv_id        (srv_id),
    .dump_req      (dump_req),
    .dump_valid    (dump_valid),
    .dump_id       (dump_id),
    .dump_done     (dump_done),
    .occupancy     (occupancy),
    .hm_mode       (hm_mode),
    .hm_studentID  (hm_studentID),
    .hm_checkInTime(hm_checkInTime),
    .hm_listOutput (m_out),
    .hm_listBusy   (m_busy),
    .hm_ready      (hm_ready)
  );

  // ---------------- heap model: sorted array is a valid min-heap ----------
  logic [4:0] h_id [10];
  logic [4:0] h_tm [10];
  int         h_n;
  int         h_idx;

  assign hm_ready = !m_busy;

  function automatic int ins_pos(input logic [4:0] t);
    int p = 0;
    for (int i = 0; i < 10; i++)
      if (i < h_n && h_tm[i] <= t) p = i + 1;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_n    <= 0;
      h_idx  <= 0;
      m_busy <= 1'b0;
      m_out  <= 5'd0;
    end else begin
      case (hm_mode)
        2'd0: begin
          if (!m_busy) begin
            if (h_n > 0) begin
              m_busy <= 1'b1;
              m_out  <= h_id[0];
              h_idx  <= 1;
            end
          end else if (h_idx < h_n) begin
            m_out <= h_id[h_idx];
            h_idx <= h_idx + 1;
          end else begin
            m_busy <= 1'b0;
            h_idx  <= 0;
          end
        end
        2'd2: begin
          if (h_n < 10) begin
            for (int i = 0; i < 10; i++) begin
              if (i > ins_pos(hm_checkInTime[4:0])) begin
                h_id[i] <= h_id[i-1];
                h_tm[i] <= h_tm[i-1];
              end else if (i == ins_pos(hm_checkInTime[4:0])) begin
                h_id[i] <= hm_studentID;
                h_tm[i] <= hm_checkInTime[4:0];
              end
            end
            h_n <= h_n + 1;
          end
          m_busy <= 1'b0;
          h_idx  <= 0;
        end
        2'd3: begin
          if (h_n > 0) begin
            for (int i = 0; i < 9; i++) begin
              h_id[i] <= h_id[i+1];
              h_tm[i] <= h_tm[i+1];
            end
            h_n <= h_n - 1;
          end
          m_busy <= 1'b0;
          h_idx  <= 0;
        end
        default: begin
          m_busy <= 1'b0;
          h_idx  <= 0;
        end
      endcase
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({hm_mode, hm_studentID, hm_checkInTime, srv_done, srv_empty, srv_id,
         dump_valid, dump_id, dump_done, occupancy, arr_ready} !==
        {2'd1, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got mode=%0d occ=%0d arr_ready=%0b srv_done=%0b dump_done=%0b",
               hm_mode, occupancy, arr_ready, srv_done, dump_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (arr_ready !== 1'b1 || hm_mode !== 2'd1) begin
      failures++;
      $display("FAIL post_reset_idle got arr_ready=%0b mode=%0d exp arr_ready=1 mode=1", arr_ready, hm_mode);
    end
  endtask

  task automatic test_empty_dump();
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    checks++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || hm_mode !== 2'd1) begin
      failures++;
      $display("FAIL empty_dump got done=%0b valid=%0b mode=%0d exp done=1 valid=0 mode=1",
               dump_done, dump_valid, hm_mode);
    end
    @(negedge clk);
    checks++;
    if (dump_done !== 1'b0) begin
      failures++;
      $display("FAIL empty_dump_pulse got done=%0b exp 0", dump_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ids [3];
    logic [4:0] e_id;
    logic [4:0] e_tm;
    ids[0] = 5'd7; ids[1] = 5'd4; ids[2] = 5'd1;
    tick = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      arr_valid = 1'b1;
      arr_id    = ids[i];
      exp_id_q.push_back(ids[i]);
      exp_tm_q.push_back(5'(2 + i));
      #1;
      checks++;
      if (arr_ready !== 1'b1) begin
        failures++;
        $display("FAIL checkin_ready[%0d] got=%0b exp=1", i, arr_ready);
      end
      @(negedge clk);
      e_id = exp_id_q.pop_front();
      e_tm = exp_tm_q.pop_front();
      checks++;
      if ({hm_mode, hm_studentID, hm_checkInTime} !== {2'd2, e_id, 3'b000, e_tm}) begin
        failures++;
        $display("FAIL checkin_cmd[%0d] got mode=%0d id=%0d time=%0d exp mode=2 id=%0d time=%0d",
                 i, hm_mode, hm_studentID, hm_checkInTime, e_id, e_tm);
      end
    end
    arr_valid = 1'b0;
    tick      = 1'b0;
    @(negedge clk);
    checks++;
    if (hm_mode !== 2'd1 || occupancy !== 4'd3) begin
      failures++;
      $display("FAIL checkin_after got mode=%0d occ=%0d exp mode=1 occ=3", hm_mode, occupancy);
    end
  endtask

  task automatic test_dump(input int n_exp);
    int   nval = 0;
    int   nmode0 = 0;
    bit   done = 0;
    logic [4:0] e;
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (hm_mode === 2'd0) nmode0++;
      if (dump_valid === 1'b1) begin
        nval++;
        checks++;
        if (exp_dump_q.size() == 0) begin
          failures++;
          $display("FAIL dump_extra got id=%0d exp no more entries", dump_id);
        end else begin
          e = exp_dump_q.pop_front();
          if (dump_id !== e) begin
            failures++;
            $display("FAIL dump_id[%0d] got=%0d exp=%0d", nval, dump_id, e);
          end
        end
      end
      if (dump_done === 1'b1) done = 1;
      else @(negedge clk);
    end
    checks++;
    if (!done || dump_valid !== 1'b1 || nval != n_exp || nmode0 != n_exp + 1) begin
      failures++;
      $display("FAIL dump_shape got done=%0b last_valid=%0b valids=%0d list_cycles=%0d exp done=1 last_valid=1 valids=%0d list_cycles=%0d",
               done, dump_valid, nval, nmode0, n_exp, n_exp + 1);
    end
    @(negedge clk);
    checks++;
    if (dump_done !== 1'b0 || dump_valid !== 1'b0 || hm_mode !== 2'd1) begin
      failures++;
      $display("FAIL dump_after got done=%0b valid=%0b mode=%0d exp 0 0 1", dump_done, dump_valid, hm_mode);
    end
  endtask

  task automatic test_serve(input logic [4:0] exp_id, input logic [3:0] exp_occ);
    logic [5:0] modes = 6'd0;
    int   n = 0;
    bit   done = 0;
    logic [4:0] e;
    exp_srv_q.push_back(exp_id);
    srv_req = 1'b1;
    @(negedge clk);
    srv_req = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      modes = {modes[3:0], hm_mode};
      n++;
      if (srv_done === 1'b1) done = 1;
      else @(negedge clk);
    end
    checks++;
    if (!done || n != 3 || modes !== {2'd0, 2'd3, 2'd1}) begin
      failures++;
      $display("FAIL serve_seq got done=%0b cycles=%0d modes=%b exp done=1 cycles=3 modes=001101",
               done, n, modes);
    end
    e = exp_srv_q.pop_front();
    checks++;
    if (srv_id !== e || srv_empty !== 1'b0 || occupancy !== exp_occ) begin
      failures++;
      $display("FAIL serve_result got id=%0d empty=%0b occ=%0d exp id=%0d empty=0 occ=%0d",
               srv_id, srv_empty, occupancy, e, exp_occ);
    end
    @(negedge clk);
    checks++;
    if (srv_done !== 1'b0) begin
      failures++;
      $display("FAIL serve_pulse got srv_done=%0b exp 0", srv_done);
    end
  endtask

  task automatic test_collision();
    srv_req   = 1'b1;
    arr_valid = 1'b1;
    arr_id    = 5'd9;
    #1;
    checks++;
    if (arr_ready !== 1'b0) begin
      failures++;
      $display("FAIL collide_ready_blocked got=%0b exp=0", arr_ready);
    end
    @(negedge clk);
    checks++;
    if (srv_done !== 1'b1 || srv_empty !== 1'b1 || srv_id !== 5'd1 || hm_mode !== 2'd1 || occupancy !== 4'd0) begin
      failures++;
      $display("FAIL empty_serve got done=%0b empty=%0b id=%0d mode=%0d occ=%0d exp 1 1 1 1 0",
               srv_done, srv_empty, srv_id, hm_mode, occupancy);
    end
    srv_req = 1'b0;
    #1;
    checks++;
    if (arr_ready !== 1'b1) begin
      failures++;
      $display("FAIL collide_ready_after got=%0b exp=1", arr_ready);
    end
    @(negedge clk);
    arr_valid = 1'b0;
    checks++;
    if (hm_mode !== 2'd2 || hm_studentID !== 5'd9 || occupancy !== 4'd1 || srv_done !== 1'b0 || srv_empty !== 1'b0) begin
      failures++;
      $display("FAIL collide_checkin got mode=%0d id=%0d occ=%0d done=%0b empty=%0b exp 2 9 1 0 0",
               hm_mode, hm_studentID, occupancy, srv_done, srv_empty);
    end
  endtask

  task automatic test_full();
    arr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      arr_id = 5'(10 + i);
      @(negedge clk);
    end
    arr_id = 5'd20;
    #1;
    checks++;
    if (occupancy !== 4'd10 || arr_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got occ=%0d ready=%0b exp occ=10 ready=0", occupancy, arr_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (hm_mode !== 2'd1 || occupancy !== 4'd10) begin
        failures++;
        $display("FAIL full_hold[%0d] got mode=%0d occ=%0d exp mode=1 occ=10", i, hm_mode, occupancy);
      end
    end
    arr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (hm_mode !== 2'd0 || dump_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_dump_active got mode=%0d valid=%0b exp mode=0 valid=1", hm_mode, dump_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (hm_mode !== 2'd1 || dump_valid !== 1'b0 || occupancy !== 4'd0 || arr_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got mode=%0d valid=%0b occ=%0d ready=%0b exp 1 0 0 0",
               hm_mode, dump_valid, occupancy, arr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dump_done !== 1'b0 || hm_mode !== 2'd1) begin
      failures++;
      $display("FAIL after_reset_quiet got done=%0b mode=%0d exp 0 1", dump_done, hm_mode);
    end
  endtask

  task automatic checkin_time(input int n_ticks, input logic [4:0] exp_t);
    tick = 1'b1;
    repeat (n_ticks) @(negedge clk);
    tick      = 1'b0;
    arr_valid = 1'b1;
    arr_id    = 5'd3;
    @(negedge clk);
    arr_valid = 1'b0;
    checks++;
    if (hm_mode !== 2'd2 || hm_checkInTime !== {3'b000, exp_t}) begin
      failures++;
      $display("FAIL time_stamp got mode=%0d time=%0d exp mode=2 time=%0d", hm_mode, hm_checkInTime, exp_t);
    end
  endtask

  task automatic test_time_saturation();
    checkin_time(30, 5'd30);
    checkin_time(10, 5'd31);
  endtask

  initial begin
    test_reset();
    test_empty_dump();
    test_back_to_back();
    exp_dump_q.push_back(5'd7);
    exp_dump_q.push_back(5'd4);
    exp_dump_q.push_back(5'd1);
    test_dump(3);
    test_serve(5'd7, 4'd2);
    test_serve(5'd4, 4'd1);
    test_serve(5'd1, 4'd0);
    test_collision();
    test_full();
    test_reset_mid_dump();
    test_time_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
